// File: rtl/nx_table_capture_if.sv
// Signal bundle between the table-capture producer, its upstream record
// stream and the double-banked table monitor.
interface nx_table_capture_if #(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 8,
  parameter int N_DROP_BITS = 16
);
  logic                   in_valid;
  logic [N_DATA_BITS-1:0] in_data;
  logic                   in_last;
  logic                   in_ready;
  logic                   tmon_credit_available;
  logic                   tmon_credit_used;
  logic [N_DATA_BITS-1:0] table_data [N_ENTRIES];
  logic                   wr_bank;
  logic [N_DROP_BITS-1:0] drop_cnt;
  logic [15:0]            commit_cnt;

  // Upstream source plus monitor side: drives records and credits.
  modport master (
    output in_valid, in_data, in_last, tmon_credit_available,
    input  in_ready, tmon_credit_used, table_data, wr_bank, drop_cnt, commit_cnt
  );

  // Capture block side.
  modport slave (
    input  in_valid, in_data, in_last, tmon_credit_available,
    output in_ready, tmon_credit_used, table_data, wr_bank, drop_cnt, commit_cnt
  );
endinterface

// File: rtl/nx_table_capture.sv
// Producer end of a double-banked table monitor: fills one bank of the table
// from a valid/ready record stream per monitor credit, then hands it over.
module nx_table_capture #(
  parameter int                     N_DATA_BITS    = 32,
  parameter int                     N_ENTRIES      = 8,
  parameter logic [N_DATA_BITS-1:0] RESET_DATA     = '0,
  parameter logic [N_DATA_BITS-1:0] PAD_DATA       = '0,
  parameter bit                     DROP_WHEN_FULL = 1'b0,
  parameter int                     N_DROP_BITS    = 16
) (
  input logic               clk,
  input logic               rst_n,
  nx_table_capture_if.slave bus
);

  localparam int B      = N_ENTRIES / 2;
  localparam int IDX_W  = (B > 1) ? $clog2(B) : 1;
  localparam int ADDR_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(B - 1);

  typedef enum logic [2:0] {
    HOLDOFF,
    WAIT_CREDIT,
    FILL,
    PAD,
    COMMIT
  } stateT;

  stateT                  state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   wrBank_q, wrBank_d;
  logic                   creditUsed_q;
  logic [N_DROP_BITS-1:0] dropCnt_q, dropCnt_d;
  logic [15:0]            commitCnt_q, commitCnt_d;
  logic [N_DATA_BITS-1:0] table_q [N_ENTRIES];

  logic                   inReady;
  logic                   accept;
  logic                   wrEn;
  logic [N_DATA_BITS-1:0] wrData;
  logic [ADDR_W-1:0]      wrAddr;

  assign accept = bus.in_valid & inReady & rst_n;
  assign wrAddr = (wrBank_q ? ADDR_W'(B) : ADDR_W'(0)) + ADDR_W'(idx_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wrBank_d    = wrBank_q;
    dropCnt_d   = dropCnt_q;
    commitCnt_d = commitCnt_q;
    wrEn        = 1'b0;
    wrData      = bus.in_data;
    inReady     = 1'b0;
    case (state_q)
      // HOLDOFF hides the monitor's credit update latency after reset or a commit.
      HOLDOFF: begin
        inReady = DROP_WHEN_FULL;
        state_d = WAIT_CREDIT;
      end
      WAIT_CREDIT: begin
        inReady = DROP_WHEN_FULL;
        if (bus.tmon_credit_available) state_d = FILL;
      end
      FILL: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          wrEn = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = COMMIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (bus.in_last) state_d = PAD;
          end
        end
      end
      PAD: begin
        wrEn   = 1'b1;
        wrData = PAD_DATA;
        if (idx_q == LAST_IDX) state_d = COMMIT;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      COMMIT: begin
        idx_d       = '0;
        wrBank_d    = ~wrBank_q;
        commitCnt_d = commitCnt_q + 16'd1;
        state_d     = HOLDOFF;
      end
      default: state_d = HOLDOFF;
    endcase
    // Records taken while no credit is held are thrown away but counted.
    if (accept && (state_q == HOLDOFF || state_q == WAIT_CREDIT) && (dropCnt_q != '1))
      dropCnt_d = dropCnt_q + N_DROP_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HOLDOFF;
      idx_q        <= '0;
      wrBank_q     <= 1'b0;
      creditUsed_q <= 1'b0;
      dropCnt_q    <= '0;
      commitCnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wrBank_q     <= wrBank_d;
      creditUsed_q <= (state_d == COMMIT);
      dropCnt_q    <= dropCnt_d;
      commitCnt_q  <= commitCnt_d;
    end
  end

  // Only the bank being filled is ever written, so the other stays readable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) table_q[i] <= RESET_DATA;
    end else if (wrEn) begin
      table_q[wrAddr] <= wrData;
    end
  end

  assign bus.in_ready         = inReady & rst_n;
  assign bus.tmon_credit_used = creditUsed_q;
  assign bus.table_data       = table_q;
  assign bus.wr_bank          = wrBank_q;
  assign bus.drop_cnt         = dropCnt_q;
  assign bus.commit_cnt       = commitCnt_q;

endmodule

// File: tb/tb_nx_table_capture.sv
// Scoreboard bench for nx_table_capture: a bank-level reference model predicts
// each handed-over bank, and a monitor checks it on every tmon_credit_used pulse.
module tb_nx_table_capture;

  localparam logic [31:0] PAD_A = 32'h0000FFFF;
  localparam int          BANK  = 4;

  logic clk;
  logic rst_n;

  nx_table_capture_if #(.N_DATA_BITS(32), .N_ENTRIES(8), .N_DROP_BITS(16)) busA ();
  nx_table_capture_if #(.N_DATA_BITS(32), .N_ENTRIES(8), .N_DROP_BITS(2))  busB ();

  nx_table_capture #(
    .N_DATA_BITS(32), .N_ENTRIES(8), .RESET_DATA(32'h0), .PAD_DATA(PAD_A),
    .DROP_WHEN_FULL(1'b0), .N_DROP_BITS(16)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA)
  );

  nx_table_capture #(
    .N_DATA_BITS(32), .N_ENTRIES(8), .RESET_DATA(32'h0), .PAD_DATA(32'h0),
    .DROP_WHEN_FULL(1'b1), .N_DROP_BITS(2)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .bus(busB)
  );

  typedef struct packed {
    logic           bank;
    logic [15:0]    cnt;
    logic [127:0]   words;
  } expBankT;

  expBankT     expQ[$];
  logic [31:0] curBank[$];
  logic        modelBank;
  logic [15:0] modelCommits;
  int          vectors;
  int          miscompares;
  bit          randomCredit;
  logic        prevUsed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: banks are lists of accepted records, padded on in_last.
  function automatic void modelAccept(input logic [31:0] data, input logic last);
    expBankT e;
    curBank.push_back(data);
    if (curBank.size() == BANK || last) begin
      while (curBank.size() < BANK) curBank.push_back(PAD_A);
      e.bank = modelBank;
      e.cnt  = modelCommits;
      for (int i = 0; i < BANK; i++) e.words[i*32 +: 32] = curBank[i];
      expQ.push_back(e);
      modelBank    = ~modelBank;
      modelCommits = modelCommits + 16'd1;
      curBank.delete();
    end
  endfunction

  task automatic randCredit();
    if (randomCredit) busA.tmon_credit_available = ($urandom_range(0, 3) != 0);
  endtask

  // Offers one record to dutA; returns at the negedge following acceptance.
  task automatic applyStimulus(input logic [31:0] data, input logic last);
    int n = 0;
    busA.in_valid = 1'b1;
    busA.in_data  = data;
    busA.in_last  = last;
    while (!busA.in_ready && n < 200) begin
      @(negedge clk);
      randCredit();
      n++;
    end
    if (!busA.in_ready) begin
      checkOutput("acceptTimeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      modelAccept(data, last);
      @(negedge clk);
      randCredit();
    end
  endtask

  task automatic idleCycles(input int n);
    busA.in_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      randCredit();
    end
  endtask

  always @(negedge clk) begin
    expBankT e;
    if (rst_n) begin
      if (busA.tmon_credit_used) begin
        checkOutput("pulseSpacing", {63'd0, prevUsed}, 64'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedPulse", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("commitBank", {63'd0, busA.wr_bank}, {63'd0, e.bank});
          checkOutput("commitCntAtPulse", {48'd0, busA.commit_cnt}, {48'd0, e.cnt});
          for (int i = 0; i < BANK; i++)
            checkOutput("bankEntry", {32'd0, busA.table_data[(e.bank ? BANK : 0) + i]},
                        {32'd0, e.words[i*32 +: 32]});
        end
      end
      if (busB.tmon_credit_used) checkOutput("dropUnitPulse", 64'd1, 64'd0);
      prevUsed = busA.tmon_credit_used;
    end else begin
      prevUsed = 1'b0;
    end
  end

  initial begin
    int n;
    vectors      = 0;
    miscompares  = 0;
    randomCredit = 1'b0;
    prevUsed     = 1'b0;
    modelBank    = 1'b0;
    modelCommits = 16'd0;
    busA.in_valid = 1'b0; busA.in_data = '0; busA.in_last = 1'b0; busA.tmon_credit_available = 1'b0;
    busB.in_valid = 1'b0; busB.in_data = '0; busB.in_last = 1'b0; busB.tmon_credit_available = 1'b0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("resetReadyA", {63'd0, busA.in_ready}, 64'd0);
    checkOutput("resetReadyB", {63'd0, busB.in_ready}, 64'd0);
    checkOutput("resetUsed", {63'd0, busA.tmon_credit_used}, 64'd0);
    checkOutput("resetWrBank", {63'd0, busA.wr_bank}, 64'd0);
    checkOutput("resetCommitCnt", {48'd0, busA.commit_cnt}, 64'd0);
    checkOutput("resetDropCnt", {48'd0, busA.drop_cnt}, 64'd0);
    for (int i = 0; i < 8; i++) checkOutput("resetTable", {32'd0, busA.table_data[i]}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Discarding unit: no credit, five records offered, counter saturates at 3.
    @(negedge clk);
    busB.in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      busB.in_data = $urandom;
      busB.in_last = $urandom_range(0, 1);
      checkOutput("dropReady", {63'd0, busB.in_ready}, 64'd1);
      @(negedge clk);
      checkOutput("dropCntSat", {62'd0, busB.drop_cnt}, (k > 3) ? 64'd3 : 64'(k));
    end
    busB.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) checkOutput("dropTableUntouched", {32'd0, busB.table_data[i]}, 64'd0);
    checkOutput("dropNoCommit", {48'd0, busB.commit_cnt}, 64'd0);

    // First burst into bank lo.
    busA.tmon_credit_available = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(32'hA0 + i, 1'b0);
    busA.in_valid = 1'b0;
    checkOutput("pulseAfterBurst1", {63'd0, busA.tmon_credit_used}, 64'd1);
    @(negedge clk);
    checkOutput("pulseOneCycle", {63'd0, busA.tmon_credit_used}, 64'd0);
    checkOutput("wrBankAfter1", {63'd0, busA.wr_bank}, 64'd1);
    checkOutput("commitCntAfter1", {48'd0, busA.commit_cnt}, 64'd1);
    for (int i = 4; i < 8; i++) checkOutput("bankHiUntouched", {32'd0, busA.table_data[i]}, 64'd0);

    // Second burst into bank hi; credit withdrawn during the commit.
    for (int i = 0; i < 4; i++) applyStimulus(32'hB0 + i, 1'b0);
    busA.tmon_credit_available = 1'b0;
    busA.in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      busA.in_data = $urandom;
      checkOutput("noReadyNoCredit", {63'd0, busA.in_ready}, 64'd0);
    end
    busA.in_valid = 1'b0;
    checkOutput("noDropBackpressure", {48'd0, busA.drop_cnt}, 64'd0);
    checkOutput("wrBankAfter2", {63'd0, busA.wr_bank}, 64'd0);
    checkOutput("commitCntAfter2", {48'd0, busA.commit_cnt}, 64'd2);
    for (int i = 0; i < 4; i++) begin
      checkOutput("bankLoKept", {32'd0, busA.table_data[i]}, 64'(32'hA0 + i));
      checkOutput("bankHiKept", {32'd0, busA.table_data[i+4]}, 64'(32'hB0 + i));
    end
    busA.tmon_credit_available = 1'b1;
    checkOutput("readyBeforeFill", {63'd0, busA.in_ready}, 64'd0);
    @(negedge clk);
    checkOutput("readyAfterCredit", {63'd0, busA.in_ready}, 64'd1);

    // Early close: two records then two pad entries.
    applyStimulus(32'hC0, 1'b0);
    applyStimulus(32'hC1, 1'b1);
    busA.in_valid = 1'b0;
    checkOutput("padReady1", {63'd0, busA.in_ready}, 64'd0);
    @(negedge clk);
    checkOutput("padReady2", {63'd0, busA.in_ready}, 64'd0);
    checkOutput("padEntry2", {32'd0, busA.table_data[2]}, 64'(PAD_A));
    @(negedge clk);
    checkOutput("pulseAfterPad", {63'd0, busA.tmon_credit_used}, 64'd1);

    // Reset in the middle of a fill.
    applyStimulus(32'hD0, 1'b0);
    applyStimulus(32'hD1, 1'b0);
    busA.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    curBank.delete();
    expQ.delete();
    modelBank    = 1'b0;
    modelCommits = 16'd0;
    checkOutput("midResetReady", {63'd0, busA.in_ready}, 64'd0);
    checkOutput("midResetWrBank", {63'd0, busA.wr_bank}, 64'd0);
    checkOutput("midResetCommit", {48'd0, busA.commit_cnt}, 64'd0);
    for (int i = 0; i < 8; i++) checkOutput("midResetTable", {32'd0, busA.table_data[i]}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("midResetNoPulse", {63'd0, busA.tmon_credit_used}, 64'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(32'hE0 + i, 1'b0);

    // Randomised records, gaps, early closes and credit availability.
    randomCredit = 1'b1;
    for (int r = 0; r < 40; r++) begin
      applyStimulus($urandom, ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end
    applyStimulus($urandom, 1'b1);
    randomCredit = 1'b0;
    busA.tmon_credit_available = 1'b1;
    busA.in_valid = 1'b0;
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainScoreboard", 64'(expQ.size()), 64'd0);
    checkOutput("finalCommitCnt", {48'd0, busA.commit_cnt}, {48'd0, modelCommits});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
